// File: rtl/shiftreg_16_right_deser.sv
// shiftreg_16_right_deser
// Serial-to-parallel receiver for the LSB-first bitstream produced by a
// right-shifting shift register. Word alignment comes from a frame-start
// strobe; assembled words are handed on through a one-entry valid/ready
// buffer, with sticky overrun and one-cycle sync-error flags.

module shiftreg_16_right_deser #(
    parameter int WIDTH        = 16,
    parameter int REQUIRE_SYNC = 1
) (
    input  logic                       Clock,
    input  logic                       Sclr_n,
    input  logic                       SerIn,
    input  logic                       SerValid,
    input  logic                       FrameStart,
    output logic [WIDTH-1:0]           Q,
    output logic                       Valid,
    input  logic                       Ready,
    output logic                       Overrun,
    input  logic                       ClrOvr,
    output logic                       SyncErr,
    output logic [$clog2(WIDTH):0]     BitCnt
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // HUNT waits for a frame start, RECV accumulates aligned bits.
    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (REQUIRE_SYNC != 0) ? HUNT : RECV;

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [WIDTH-1:0]  r_q;
    logic              r_valid;
    logic              r_overrun;
    logic              r_syncErr;

    logic              w_restart;
    logic              w_take;
    logic              w_syncErr;
    logic [WIDTH-1:0]  w_accBase;
    logic [WIDTH-1:0]  w_shifted;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_complete;
    logic              w_drain;
    logic              w_load;
    logic              w_drop;

    // Decode what the current bit does: start a word, extend one, complete one,
    // and whether the output buffer can take a completed word this cycle.
    always_comb begin
        w_restart  = SerValid && FrameStart;
        w_take     = SerValid && (FrameStart || (r_state == RECV));
        w_syncErr  = w_restart && (r_state == RECV) && (r_bitCnt != '0);
        w_accBase  = w_restart ? '0 : r_acc;
        w_shifted  = {SerIn, w_accBase[WIDTH-1:1]};
        w_cntNext  = w_restart ? ONE_CNT : (r_bitCnt + ONE_CNT);
        w_complete = w_take && (w_cntNext == LAST_CNT);
        w_drain    = r_valid && Ready;
        w_load     = w_complete && (!r_valid || w_drain);
        w_drop     = w_complete && r_valid && !w_drain;
    end

    // Receiver state, accumulator, output buffer and flags, all registered.
    always_ff @(posedge Clock) begin
        if (!Sclr_n) begin
            r_state   <= RESET_STATE;
            r_acc     <= '0;
            r_bitCnt  <= '0;
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_syncErr <= 1'b0;
        end else begin
            r_syncErr <= w_syncErr;

            if (w_take) begin
                r_state <= RECV;
                if (w_complete) begin
                    r_acc    <= '0;
                    r_bitCnt <= '0;
                end else begin
                    r_acc    <= w_shifted;
                    r_bitCnt <= w_cntNext;
                end
            end

            if (w_load) begin
                r_q     <= w_shifted;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ClrOvr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign Q       = r_q;
    assign Valid   = r_valid;
    assign Overrun = r_overrun;
    assign SyncErr = r_syncErr;
    assign BitCnt  = r_bitCnt;

endmodule

// File: tb/tb_shiftreg_16_right_deser.sv
// tb_shiftreg_16_right_deser
// Scenario-based bench: words expected at the output are queued when their
// bits are driven and popped whenever the DUT hands a word over.

module tb_shiftreg_16_right_deser;

    logic        Clock = 1'b0;
    logic        Sclr_n = 1'b1;
    logic        SerIn = 1'b0;
    logic        SerValid = 1'b0;
    logic        FrameStart = 1'b0;
    logic [15:0] Q;
    logic        Valid;
    logic        Ready = 1'b0;
    logic        Overrun;
    logic        ClrOvr = 1'b0;
    logic        SyncErr;
    logic [4:0]  BitCnt;

    int passCount  = 0;
    int checkCount = 0;
    logic [15:0] expectQ[$];

    shiftreg_16_right_deser #(.WIDTH(16), .REQUIRE_SYNC(1)) dut (
        .Clock      (Clock),
        .Sclr_n     (Sclr_n),
        .SerIn      (SerIn),
        .SerValid   (SerValid),
        .FrameStart (FrameStart),
        .Q          (Q),
        .Valid      (Valid),
        .Ready      (Ready),
        .Overrun    (Overrun),
        .ClrOvr     (ClrOvr),
        .SyncErr    (SyncErr),
        .BitCnt     (BitCnt)
    );

    always #5 Clock = ~Clock;

    // Scoreboard: every handshake seen between edges must match the oldest queued word.
    always @(negedge Clock) begin
        if (Sclr_n && Valid && Ready) begin
            checkCount++;
            if (expectQ.size() == 0) begin
                $display("[TB] FAIL scoreboard_unexpected: got Q=%h, no word expected", Q);
            end else begin
                logic [15:0] exp;
                exp = expectQ.pop_front();
                if (Q !== exp)
                    $display("[TB] FAIL scoreboard_word: got Q=%h, expected %h", Q, exp);
                else
                    passCount++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic sendBit(input logic b, input logic fs);
        SerIn      = b;
        SerValid   = 1'b1;
        FrameStart = fs;
        tick();
        SerValid   = 1'b0;
        FrameStart = 1'b0;
    endtask

    task automatic sendBits(input logic [15:0] data, input int startIdx, input int count,
                            input logic fsFirst);
        for (int i = 0; i < count; i++)
            sendBit(data[startIdx + i], fsFirst && (i == 0));
    endtask

    task automatic doReset();
        Sclr_n = 1'b0;
        tick();
        Sclr_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        checkCount++;
        if (Q !== 16'h0 || Valid !== 1'b0 || Overrun !== 1'b0 || SyncErr !== 1'b0 || BitCnt !== 5'd0)
            $display("[TB] FAIL reset_state: got Q=%h V=%b O=%b S=%b C=%0d, expected all zero",
                     Q, Valid, Overrun, SyncErr, BitCnt);
        else
            passCount++;
    endtask

    task automatic test_alignment();
        Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sendBit(i[0], 1'b0);
            checkCount++;
            if (BitCnt !== 5'd0) $display("[TB] FAIL hunt_discard: got BitCnt=%0d, expected 0", BitCnt);
            else passCount++;
        end
        expectQ.push_back(16'hA5C3);
        sendBits(16'hA5C3, 0, 1, 1'b1);
        checkCount++;
        if (BitCnt !== 5'd1) $display("[TB] FAIL align_first_bit: got BitCnt=%0d, expected 1", BitCnt);
        else passCount++;
        sendBits(16'hA5C3, 1, 15, 1'b0);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'hA5C3 || BitCnt !== 5'd0)
            $display("[TB] FAIL align_word: got V=%b Q=%h C=%0d, expected V=1 Q=a5c3 C=0", Valid, Q, BitCnt);
        else passCount++;
        tick();
        checkCount++;
        if (Valid !== 1'b0) $display("[TB] FAIL align_single_pulse: got V=%b, expected 0", Valid);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        Ready = 1'b1;
        expectQ.push_back(16'h1234);
        expectQ.push_back(16'hFFFE);
        sendBits(16'h1234, 0, 16, 1'b1);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h1234)
            $display("[TB] FAIL b2b_first: got V=%b Q=%h, expected V=1 Q=1234", Valid, Q);
        else passCount++;
        sendBits(16'hFFFE, 0, 1, 1'b0);
        checkCount++;
        if (Valid !== 1'b0) $display("[TB] FAIL b2b_gap: got V=%b, expected 0", Valid);
        else passCount++;
        sendBits(16'hFFFE, 1, 15, 1'b0);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'hFFFE || Overrun !== 1'b0)
            $display("[TB] FAIL b2b_second: got V=%b Q=%h O=%b, expected V=1 Q=fffe O=0", Valid, Q, Overrun);
        else passCount++;
        tick();
    endtask

    task automatic test_overrun();
        Ready = 1'b0;
        expectQ.push_back(16'h0001);
        sendBits(16'h0001, 0, 16, 1'b1);
        sendBits(16'h0002, 0, 16, 1'b0);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h0001 || Overrun !== 1'b1)
            $display("[TB] FAIL overrun_set: got V=%b Q=%h O=%b, expected V=1 Q=0001 O=1", Valid, Q, Overrun);
        else passCount++;
        Ready  = 1'b1;
        ClrOvr = 1'b1;
        tick();
        ClrOvr = 1'b0;
        checkCount++;
        if (Valid !== 1'b0 || Overrun !== 1'b0 || Q !== 16'h0001)
            $display("[TB] FAIL overrun_clear: got V=%b O=%b Q=%h, expected V=0 O=0 Q=0001", Valid, Overrun, Q);
        else passCount++;
    endtask

    task automatic test_resync();
        Ready = 1'b1;
        sendBits(16'h007F, 0, 7, 1'b1);
        expectQ.push_back(16'h8001);
        sendBits(16'h8001, 0, 1, 1'b1);
        checkCount++;
        if (SyncErr !== 1'b1 || BitCnt !== 5'd1)
            $display("[TB] FAIL resync_pulse: got S=%b C=%0d, expected S=1 C=1", SyncErr, BitCnt);
        else passCount++;
        sendBits(16'h8001, 1, 1, 1'b0);
        checkCount++;
        if (SyncErr !== 1'b0) $display("[TB] FAIL resync_one_cycle: got S=%b, expected 0", SyncErr);
        else passCount++;
        sendBits(16'h8001, 2, 14, 1'b0);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h8001)
            $display("[TB] FAIL resync_word: got V=%b Q=%h, expected V=1 Q=8001", Valid, Q);
        else passCount++;
        tick();
    endtask

    task automatic test_reset_midword();
        Ready = 1'b0;
        sendBits(16'h0003, 0, 16, 1'b1);
        sendBits(16'h0004, 0, 16, 1'b0);
        sendBits(16'h01FF, 0, 9, 1'b1);
        checkCount++;
        if (Valid !== 1'b1 || Overrun !== 1'b1 || BitCnt !== 5'd9)
            $display("[TB] FAIL midword_setup: got V=%b O=%b C=%0d, expected V=1 O=1 C=9", Valid, Overrun, BitCnt);
        else passCount++;
        doReset();
        checkCount++;
        if (Q !== 16'h0 || Valid !== 1'b0 || Overrun !== 1'b0 || SyncErr !== 1'b0 || BitCnt !== 5'd0)
            $display("[TB] FAIL midword_reset: got Q=%h V=%b O=%b S=%b C=%0d, expected all zero",
                     Q, Valid, Overrun, SyncErr, BitCnt);
        else passCount++;
        Ready = 1'b1;
        sendBit(1'b1, 1'b0);
        checkCount++;
        if (BitCnt !== 5'd0) $display("[TB] FAIL midword_hunt: got BitCnt=%0d, expected 0", BitCnt);
        else passCount++;
        expectQ.push_back(16'h5555);
        sendBits(16'h5555, 0, 16, 1'b1);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h5555)
            $display("[TB] FAIL midword_recover: got V=%b Q=%h, expected V=1 Q=5555", Valid, Q);
        else passCount++;
        tick();
    endtask

    task automatic test_complete_drain();
        Ready = 1'b0;
        expectQ.push_back(16'h00AA);
        expectQ.push_back(16'h00BB);
        sendBits(16'h00AA, 0, 16, 1'b1);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h00AA)
            $display("[TB] FAIL drain_hold: got V=%b Q=%h, expected V=1 Q=00aa", Valid, Q);
        else passCount++;
        sendBits(16'h00BB, 0, 15, 1'b0);
        Ready = 1'b1;
        sendBits(16'h00BB, 15, 1, 1'b0);
        checkCount++;
        if (Valid !== 1'b1 || Q !== 16'h00BB || Overrun !== 1'b0)
            $display("[TB] FAIL drain_same_edge: got V=%b Q=%h O=%b, expected V=1 Q=00bb O=0", Valid, Q, Overrun);
        else passCount++;
        tick();
        checkCount++;
        if (Valid !== 1'b0) $display("[TB] FAIL drain_empty: got V=%b, expected 0", Valid);
        else passCount++;
    endtask

    initial begin
        tick();
        test_reset();
        test_alignment();
        test_back_to_back();
        test_overrun();
        test_resync();
        test_reset_midword();
        test_complete_drain();
        tick();
        checkCount++;
        if (expectQ.size() != 0)
            $display("[TB] FAIL scoreboard_drained: got %0d words left, expected 0", expectQ.size());
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shiftreg_16_right_deser.md
# shiftreg_16_right_deser

Serial-to-parallel receiver that sits directly downstream of the 16-bit right-shifting LPM shift register. It consumes that register's LSB-first `ShiftOut` bitstream and acquires word alignment from a frame-start strobe. It reassembles 16-bit words and hands them to the next stage through a one-entry valid/ready output buffer. Alignment loss and overrun are reported as flags.

## Interface
Parameters:
- `WIDTH`, 16, word width; also the number of bits per word.
- `REQUIRE_SYNC`, 1, 1: after reset, ignore bits until the first `FrameStart`; 0: start receiving immediately, with the first valid bit as bit 0.

Ports:
- `Clock`  in  1  single clock; all state updates on its rising edge.
- `Sclr_n`  in  1  reset, synchronous, active-low.
- `SerIn`  in  1  serial data, taken from the upstream `ShiftOut`, LSB first.
- `SerValid`  in  1  `SerIn` carries a bit this cycle; tie to the upstream shift `Enable`.
- `FrameStart`  in  1  qualified by `SerValid`; marks the current bit as bit 0 of a word.
- `Q`  out  WIDTH  assembled word held in the output buffer.
- `Valid`  out  1  `Q` holds an unconsumed word.
- `Ready`  in  1  downstream accepts `Q` when `Valid && Ready`.
- `Overrun`  out  1  sticky; a completed word was dropped because the buffer was full.
- `ClrOvr`  in  1  clears `Overrun`.
- `SyncErr`  out  1  one-cycle pulse; `FrameStart` arrived in mid-word.
- `BitCnt`  out  log2(WIDTH)+1  number of bits accumulated in the current word.

## Operation
- States:
  - HUNT: not aligned. The reset state when `REQUIRE_SYNC`=1.
  - RECV: aligned. The reset state when `REQUIRE_SYNC`=0.
- HUNT:
  - Bits with `FrameStart`=0 are discarded and `BitCnt` stays 0.
  - When `SerValid && FrameStart`, that bit is stored as bit 0, `BitCnt` becomes 1 and the state moves to RECV.
- RECV, on each `SerValid`: `acc <= {SerIn, acc[WIDTH-1:1]}` (right shift into the MSB) and `BitCnt` increments. After WIDTH bits, the first bit received is in `acc[0]`.
- Word completion: the bit that brings `BitCnt` to WIDTH completes the word.
  - `BitCnt` returns to 0 and the state remains RECV, so back-to-back words need no gap.
  - The completed word goes to the output buffer as described below.
- `FrameStart` in RECV:
  - With `BitCnt`=0: normal alignment, no error.
  - With `BitCnt`≠0: the partial word is discarded, `SyncErr` pulses for one cycle, the current bit becomes bit 0 and `BitCnt` becomes 1.
- Output buffer:
  - A completed word loads `Q` and sets `Valid` when the buffer is empty, or when it is being drained in the same cycle (`Valid && Ready`).
  - Otherwise the word is dropped, `Q` is unchanged and `Overrun` is set.
  - A drain with no completion in the same cycle clears `Valid`. `Q` retains its last value.
- `ClrOvr` clears `Overrun`. If an overrun event occurs in the same cycle, set wins.
- `SerValid`=0: no state change except buffer drain and `ClrOvr`. `FrameStart` is ignored.
- Reset (`Sclr_n`=0 at a clock edge) overrides everything, including in mid-word:
  - `Q`=0, `Valid`=0, `Overrun`=0, `SyncErr`=0, `BitCnt`=0.
  - State = HUNT, or RECV when `REQUIRE_SYNC`=0.
  - The accumulator is cleared.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Latency: when the WIDTH-th bit is sampled at edge N, `Q` and `Valid` are updated after edge N.
- `Valid` stays high until the edge at which `Valid && Ready` is sampled.
- `Ready` may be high while `Valid` is low; this has no effect.
- Throughput: one word per WIDTH `SerValid` cycles. With `Ready` held high, no overrun is possible.
- `SyncErr` is high for exactly the one cycle after the offending edge.
- The same-edge case of completion plus drain is lossless: the new word replaces the drained one and `Valid` stays 1.
- `BitCnt` range is 0..WIDTH-1 when observed.

## Test plan
- Alignment and bit order:
  - Stimulus: reset, then 3 junk bits without `FrameStart`, then `FrameStart` and the 16 bits of 0xA5C3 LSB-first, `Ready`=1.
  - Required: `Q`=0xA5C3 and `Valid`=1 for one cycle after the 16th edge; junk bits are ignored.
- Back-to-back words:
  - Stimulus: 0x1234 then 0xFFFE streamed continuously with `SerValid`=1 and a single `FrameStart`.
  - Required: two `Valid` pulses exactly 16 cycles apart, carrying 0x1234 then 0xFFFE, with no overrun.
- Overrun:
  - Stimulus: `Ready`=0; send 0x0001 then 0x0002.
  - Required: `Q`=0x0001 is held and `Overrun`=1 after the 32nd bit.
  - Then raise `Ready` with `ClrOvr`. Required: `Valid`→0 and `Overrun`→0; 0x0002 is lost.
- Resync:
  - Stimulus: `FrameStart` at bit 7 of a word, then 16 bits of 0x8001.
  - Required: a `SyncErr` pulse, then `Q`=0x8001; the partial word is never presented.
- Reset mid-word:
  - Stimulus: `Sclr_n`=0 for one edge after 9 bits, with `Valid`=1 and `Overrun`=1 beforehand.
  - Required: all outputs return to their reset values; a subsequent framed 0x5555 is received correctly.
- Simultaneous completion and drain:
  - Stimulus: `Valid`=1 holding 0x00AA, with `Ready`=1 on the same edge the next word 0x00BB completes.
  - Required: `Valid` stays 1, `Q`=0x00BB, `Overrun`=0.
